// File: rtl/sram_mem_ctrl_pkg.sv
// sram_mem_ctrl_pkg
//   Shared definitions for the SRAM memory controller: FSM state encoding,
//   idle level of the active-low SRAM strobes, data/counter widths, default
//   timing constants and the phase-counter load helper.
package sram_mem_ctrl_pkg;

   localparam int DATA_W       = 16;
   localparam int CNT_W        = 4;
   localparam int DEF_RD_WAIT  = 1;
   localparam int DEF_WR_PULSE = 1;

   localparam logic STROBE_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ACT   = 3'd1,
      ST_RD_CAP   = 3'd2,
      ST_WR_SETUP = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_HOLD  = 3'd5
   } state_t;

   // A phase lasting 'cycles' clocks loads cycles-1 and leaves at terminal count 0.
   function automatic logic [CNT_W-1:0] phase_load(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/sram_dq_io.sv
// sram_dq_io
//   Tri-state pad for the SRAM DQ bus with a registered output enable and
//   output data register, plus the read-capture register behind cpu_rdata.
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset (releases the bus, clears rdata)
//   drive_set  load wdata and start driving DQ on the next edge
//   drive_clr  stop driving DQ on the next edge
//   wdata      data to drive
//   capture    sample DQ into rdata on the next edge
//   rdata      captured read data, held until the next capture
//   dq         SRAM data bus
module sram_dq_io
   import sram_mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              drive_set,
   input  logic              drive_clr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              capture,
   output logic [DATA_W-1:0] rdata,
   inout  wire  [DATA_W-1:0] dq
);

   logic              drive;
   logic [DATA_W-1:0] dout;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drive <= 1'b0;
         dout  <= '0;
      end else if (drive_set) begin
         drive <= 1'b1;
         dout  <= wdata;
      end else if (drive_clr) begin
         drive <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (capture) begin
         rdata <= dq;
      end
   end

   assign dq = drive ? dout : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl
//   Memory-side responder for the CPU control FSM. Services fetch/load/store
//   requests by sequencing an asynchronous 16-bit SRAM with programmable wait
//   states and answers through a req/ready + done handshake.
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       request (held until accepted on req&ready)
//   cpu_ready                   high in IDLE only
//   cpu_done                    one-cycle pulse: read data valid / write done
//   cpu_rdata                   last read data
//   sram_addr                   zero-extended word address
//   sram_dq                     tri-state data bus
//   sram_ce_n/oe_n/we_n/ub_n/lb_n  active-low strobes
// Build option
//   SRAM_MEM_CTRL_POST_WR_EN    write posting: done pulses the cycle after a
//                               write is accepted instead of in WR_HOLD.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | ready for a request, strobes idle
// ST_RD_ACT   | CE/OE low, address driven, RD_WAIT+1 cycles
// ST_RD_CAP   | DQ captured on entry, done pulse, strobes released
// ST_WR_SETUP | CE low, DQ driven, WE high, 1 cycle
// ST_WR_PULSE | WE low for WR_PULSE cycles
// ST_WR_HOLD  | WE high, DQ still driven, 1 cycle (done unless posted)
module sram_mem_ctrl
   import sram_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int SRAM_ADDR_W = 18,
   parameter int RD_WAIT     = DEF_RD_WAIT,
   parameter int WR_PULSE    = DEF_WR_PULSE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_req,
   input  logic                   cpu_we,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [DATA_W-1:0]      cpu_wdata,
   output logic                   cpu_ready,
   output logic                   cpu_done,
   output logic [DATA_W-1:0]      cpu_rdata,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   inout  wire  [DATA_W-1:0]      sram_dq,
   output logic                   sram_ce_n,
   output logic                   sram_oe_n,
   output logic                   sram_we_n,
   output logic                   sram_ub_n,
   output logic                   sram_lb_n
);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             drive_set;
   logic             drive_clr;
   logic             capture;

   // cpu_ready is only ever high in IDLE, so this is the IDLE accept.
   assign accept    = cpu_req & cpu_ready;
   // DQ is driven from WR_SETUP entry until WR_HOLD exit; OE is never low then.
   assign drive_set = accept & cpu_we;
   assign drive_clr = (state == ST_WR_HOLD);
   // Sample DQ on the edge that leaves RD_ACT, while OE is still low.
   assign capture   = (state == ST_RD_ACT) && (cnt == '0);

   sram_dq_io u_dq_io (
      .clk       (clk),
      .reset     (reset),
      .drive_set (drive_set),
      .drive_clr (drive_clr),
      .wdata     (cpu_wdata),
      .capture   (capture),
      .rdata     (cpu_rdata),
      .dq        (sram_dq)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         cpu_ready <= 1'b0;
         cpu_done  <= 1'b0;
         sram_addr <= '0;
         sram_ce_n <= STROBE_IDLE;
         sram_oe_n <= STROBE_IDLE;
         sram_we_n <= STROBE_IDLE;
         sram_ub_n <= STROBE_IDLE;
         sram_lb_n <= STROBE_IDLE;
      end else begin
         cpu_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  cpu_ready <= 1'b0;
                  sram_addr <= SRAM_ADDR_W'(cpu_addr);
                  sram_ce_n <= 1'b0;
                  sram_ub_n <= 1'b0;
                  sram_lb_n <= 1'b0;
                  if (cpu_we) begin
                     state <= ST_WR_SETUP;
`ifdef SRAM_MEM_CTRL_POST_WR_EN
                     cpu_done <= 1'b1;
`endif
                  end else begin
                     state     <= ST_RD_ACT;
                     sram_oe_n <= 1'b0;
                     cnt       <= phase_load(RD_WAIT + 1);
                  end
               end else begin
                  cpu_ready <= 1'b1;
               end
            end
            ST_RD_ACT: begin
               if (cnt == '0) begin
                  state     <= ST_RD_CAP;
                  cpu_done  <= 1'b1;
                  sram_ce_n <= STROBE_IDLE;
                  sram_oe_n <= STROBE_IDLE;
                  sram_ub_n <= STROBE_IDLE;
                  sram_lb_n <= STROBE_IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RD_CAP: begin
               state     <= ST_IDLE;
               cpu_ready <= 1'b1;
            end
            ST_WR_SETUP: begin
               state     <= ST_WR_PULSE;
               sram_we_n <= 1'b0;
               cnt       <= phase_load(WR_PULSE);
            end
            ST_WR_PULSE: begin
               if (cnt == '0) begin
                  state     <= ST_WR_HOLD;
                  sram_we_n <= STROBE_IDLE;
`ifndef SRAM_MEM_CTRL_POST_WR_EN
                  cpu_done  <= 1'b1;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_WR_HOLD: begin
               state     <= ST_IDLE;
               cpu_ready <= 1'b1;
               sram_ce_n <= STROBE_IDLE;
               sram_ub_n <= STROBE_IDLE;
               sram_lb_n <= STROBE_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               cpu_ready <= 1'b0;
               sram_ce_n <= STROBE_IDLE;
               sram_oe_n <= STROBE_IDLE;
               sram_we_n <= STROBE_IDLE;
               sram_ub_n <= STROBE_IDLE;
               sram_lb_n <= STROBE_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl
//   Two controller instances (A: RD_WAIT=1, WR_PULSE=2; B: RD_WAIT=0,
//   WR_PULSE=1), each with a behavioural asynchronous SRAM on its pins and a
//   scoreboard of expected completions filled at accept time.
`timescale 1ns/1ps
module tb_sram_mem_ctrl;

   localparam int NI         = 2;
   localparam int RD_WAIT_A  = 1;
   localparam int WR_PULSE_A = 2;
   localparam int RD_WAIT_B  = 0;
   localparam int WR_PULSE_B = 1;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      int          acc;
   } sb_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   logic        req    [NI];
   logic        we_c   [NI];
   logic [15:0] caddr  [NI];
   logic [15:0] cwdata [NI];
   logic        ready  [NI];
   logic        done   [NI];
   logic [15:0] rdata  [NI];
   logic [17:0] saddr  [NI];
   logic        ce_n   [NI];
   logic        oe_n   [NI];
   logic        we_n   [NI];
   logic        ub_n   [NI];
   logic        lb_n   [NI];
   logic [15:0] dq_s   [NI];
   wire  [15:0] dq_a;
   wire  [15:0] dq_b;

   logic [15:0] mem     [NI][256];
   bit          mvalid  [NI][256];
   logic [15:0] ref_mem [NI][256];
   bit          rvalid  [NI][256];
   int          wlow    [NI];

   sb_t sbq0[$];
   sb_t sbq1[$];
   sb_t mon_e;

   function automatic logic [15:0] init_val(input int k, input logic [7:0] a);
      if (a == 8'h10) return 16'hBEEF;
      return {(k == 0) ? 8'hC3 : 8'h5A, a};
   endfunction

   function automatic int rd_lat(input int k);
      return ((k == 0) ? RD_WAIT_A : RD_WAIT_B) + 2;
   endfunction

   function automatic int wr_pulse(input int k);
      return (k == 0) ? WR_PULSE_A : WR_PULSE_B;
   endfunction

   function automatic int wr_lat(input int k);
`ifdef SRAM_MEM_CTRL_POST_WR_EN
      return 1;
`else
      return wr_pulse(k) + 2;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fail_timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed timeout expected event", tag);
   endtask

   sram_mem_ctrl #(.RD_WAIT(RD_WAIT_A), .WR_PULSE(WR_PULSE_A)) u_dut_a (
      .clk(clk), .reset(rst_n),
      .cpu_req(req[0]), .cpu_we(we_c[0]), .cpu_addr(caddr[0]), .cpu_wdata(cwdata[0]),
      .cpu_ready(ready[0]), .cpu_done(done[0]), .cpu_rdata(rdata[0]),
      .sram_addr(saddr[0]), .sram_dq(dq_a),
      .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
      .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
   );

   sram_mem_ctrl #(.RD_WAIT(RD_WAIT_B), .WR_PULSE(WR_PULSE_B)) u_dut_b (
      .clk(clk), .reset(rst_n),
      .cpu_req(req[1]), .cpu_we(we_c[1]), .cpu_addr(caddr[1]), .cpu_wdata(cwdata[1]),
      .cpu_ready(ready[1]), .cpu_done(done[1]), .cpu_rdata(rdata[1]),
      .sram_addr(saddr[1]), .sram_dq(dq_b),
      .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
      .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
   );

   // Behavioural SRAMs: drive DQ while CE and OE are low; an undriven bus reads 0.
   pulldown pd_a (dq_a);
   pulldown pd_b (dq_b);
   assign dq_a = (!ce_n[0] && !oe_n[0])
                 ? (mvalid[0][saddr[0][7:0]] ? mem[0][saddr[0][7:0]] : init_val(0, saddr[0][7:0]))
                 : 16'hzzzz;
   assign dq_b = (!ce_n[1] && !oe_n[1])
                 ? (mvalid[1][saddr[1][7:0]] ? mem[1][saddr[1][7:0]] : init_val(1, saddr[1][7:0]))
                 : 16'hzzzz;
   assign dq_s[0] = dq_a;
   assign dq_s[1] = dq_b;

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst_n && !ce_n[k] && !we_n[k]) begin
            mem[k][saddr[k][7:0]]    <= dq_s[k];
            mvalid[k][saddr[k][7:0]] <= 1'b1;
         end
      end
   end

   function automatic void sb_push(input int k, input sb_t e);
      if (k == 0) sbq0.push_back(e); else sbq1.push_back(e);
   endfunction

   function automatic int sb_size(input int k);
      return (k == 0) ? sbq0.size() : sbq1.size();
   endfunction

   function automatic sb_t sb_pop(input int k);
      if (k == 0) return sbq0.pop_front();
      return sbq1.pop_front();
   endfunction

   // Monitor: pin invariants, WE pulse width, scoreboard push on accept, pop on done.
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            wlow[k] = 0;
            if (k == 0) sbq0.delete(); else sbq1.delete();
         end else if (started) begin
            chk($sformatf("ublb_%0d", k), {ub_n[k], lb_n[k]}, {ce_n[k], ce_n[k]});
            if (!we_n[k]) chk($sformatf("oe_in_write_%0d", k), oe_n[k], 1'b1);
            if (ready[k]) chk($sformatf("ready_idle_ce_%0d", k), ce_n[k], 1'b1);
            if (ce_n[k]) chk($sformatf("dq_released_%0d", k), dq_s[k], 16'h0000);
            if (!we_n[k]) begin
               wlow[k]++;
            end else if (wlow[k] != 0) begin
               chk($sformatf("we_pulse_%0d", k), wlow[k], wr_pulse(k));
               wlow[k] = 0;
            end
            if (req[k] && ready[k]) begin
               mon_e.w   = we_c[k];
               mon_e.a   = caddr[k];
               mon_e.acc = cyc + 1;
               if (we_c[k]) begin
                  mon_e.d = cwdata[k];
                  ref_mem[k][caddr[k][7:0]] = cwdata[k];
                  rvalid[k][caddr[k][7:0]]  = 1'b1;
               end else begin
                  mon_e.d = rvalid[k][caddr[k][7:0]] ? ref_mem[k][caddr[k][7:0]]
                                                     : init_val(k, caddr[k][7:0]);
               end
               sb_push(k, mon_e);
            end
            if (done[k]) begin
               if (sb_size(k) == 0) begin
                  chk($sformatf("spurious_done_%0d", k), 1, 0);
               end else begin
                  mon_e = sb_pop(k);
                  chk($sformatf("latency_%0d", k), cyc - mon_e.acc + 1,
                      mon_e.w ? wr_lat(k) : rd_lat(k));
                  chk($sformatf("sram_addr_%0d", k), saddr[k], {2'b00, mon_e.a});
                  if (!mon_e.w) chk($sformatf("rdata_%0d", k), rdata[k], mon_e.d);
               end
            end
         end
      end
   end

   task automatic issue(input int k, input logic w, input logic [15:0] a,
                        input logic [15:0] d, output int acc_edge);
      req[k]    = 1'b1;
      we_c[k]   = w;
      caddr[k]  = a;
      cwdata[k] = d;
      acc_edge  = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ready[k]) begin
            acc_edge = cyc + 1;
            break;
         end
      end
      if (acc_edge < 0) fail_timeout($sformatf("accept_timeout_%0d", k));
      @(posedge clk);
      #1;
   endtask

   task automatic drop_req(input int k);
      req[k] = 1'b0;
   endtask

   task automatic drain(input int k);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb_size(k) == 0 && ready[k]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_timeout($sformatf("drain_timeout_%0d", k));
   endtask

   initial begin
      int acc [4];
      int aw;
      int ar;
      bit seen;
      for (int k = 0; k < NI; k++) begin
         req[k] = 1'b0; we_c[k] = 1'b0; caddr[k] = '0; cwdata[k] = '0;
      end
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", ready[k], 1'b0);
         chk("rst_done", done[k], 1'b0);
         chk("rst_rdata", rdata[k], 16'h0000);
         chk("rst_saddr", saddr[k], 18'h0);
         chk("rst_strobes", {ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k]}, 5'b11111);
         chk("rst_dq", dq_s[k], 16'h0000);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk("ready_before_first_edge", ready[k], 1'b0);
      @(negedge clk);
      for (int k = 0; k < NI; k++) chk("ready_after_release", ready[k], 1'b1);
      started = 1'b1;

      // Read 0x0010 on A, RD_WAIT=1: latency 3, data 0xBEEF, held afterwards.
      issue(0, 1'b0, 16'h0010, 16'h0, aw);
      drop_req(0);
      drain(0);
      chk("t2_rdata", rdata[0], 16'hBEEF);
      repeat (3) @(negedge clk);
      chk("t2_rdata_held", rdata[0], 16'hBEEF);

      // Write 0x1234 -> 0x00FF then read it back on A.
      issue(0, 1'b1, 16'h00FF, 16'h1234, aw);
      drop_req(0);
      drain(0);
      chk("t3_sram_content", mem[0][8'hFF], 16'h1234);
      issue(0, 1'b0, 16'h00FF, 16'h0, ar);
      drop_req(0);
      drain(0);
      chk("t3_readback", rdata[0], 16'h1234);

      // Back-to-back fetches 0..3 with cpu_req held.
      for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'(i), 16'h0, acc[i]);
      drop_req(0);
      drain(0);
      for (int i = 0; i < 3; i++) chk("t4_accept_spacing", acc[i+1] - acc[i], RD_WAIT_A + 3);
      chk("t4_last_rdata", rdata[0], init_val(0, 8'h03));

      // Instance B, RD_WAIT=0 / WR_PULSE=1.
      issue(1, 1'b0, 16'h0010, 16'h0, ar);
      drop_req(1);
      drain(1);
      chk("t5_rdata", rdata[1], 16'hBEEF);
      issue(1, 1'b1, 16'h0020, 16'h5A5A, aw);
      drop_req(1);
      drain(1);
      issue(1, 1'b0, 16'h0020, 16'h0, ar);
      drop_req(1);
      drain(1);
      chk("t5_readback", rdata[1], 16'h5A5A);

      // Write immediately followed by a read of the same word.
      issue(1, 1'b1, 16'h0030, 16'h0F0F, aw);
      issue(1, 1'b0, 16'h0030, 16'h0, ar);
      drop_req(1);
      drain(1);
      chk("t6_read_accept_after_hold", ar - aw, WR_PULSE_B + 3);
      chk("t6_readback", rdata[1], 16'h0F0F);

      // Reset asserted while WE is low on A.
      issue(0, 1'b1, 16'h0055, 16'hDEAD, aw);
      drop_req(0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!we_n[0]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) fail_timeout("t1_we_low_timeout");
      #2 rst_n = 1'b0;
      #1;
      chk("t1_we_n", we_n[0], 1'b1);
      chk("t1_ce_n", ce_n[0], 1'b1);
      chk("t1_dq_released", dq_s[0], 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t1_ready_low", ready[0], 1'b0);
      chk("t1_no_retry_we", we_n[0], 1'b1);
      @(negedge clk);
      chk("t1_ready_high", ready[0], 1'b1);
      chk("t1_no_retry_ce", ce_n[0], 1'b1);
      issue(0, 1'b0, 16'h0010, 16'h0, ar);
      drop_req(0);
      drain(0);
      chk("t1_read_after_reset", rdata[0], 16'hBEEF);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
